master_in_port: RTL and testbench

Master-side receiver for the single-wire serial data link driven by the slave output port. It asserts `master_ready` when it can accept a byte and detects the handshake `data_ready & master_ready` on the same clock edge as the slave does. It then shifts in 8 bits LSB-first from `rx_data`, checks framing against `slave_tx_done`, and presents the byte to the master core through a one-entry valid/ack holding register.

---
 rtl/master_in_port_if.sv | 42 ++++
 rtl/master_in_port.sv | 124 ++++++++++++
 tb/tb_master_in_port.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/master_in_port_if.sv
// Bundle of the serial-link receive signals and the core-side holding register
// of master_in_port. The master modport is the receiver, the slave modport its environment.
interface master_in_port_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  rx_en;
   logic                  data_ready;
   logic                  rx_data;
   logic                  slave_tx_done;
   logic                  dout_ack;
   logic                  master_ready;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  busy;
   logic                  frame_err;

   modport master (
      input  rx_en,
      input  data_ready,
      input  rx_data,
      input  slave_tx_done,
      input  dout_ack,
      output master_ready,
      output dout,
      output dout_valid,
      output busy,
      output frame_err
   );

   modport slave (
      output rx_en,
      output data_ready,
      output rx_data,
      output slave_tx_done,
      output dout_ack,
      input  master_ready,
      input  dout,
      input  dout_valid,
      input  busy,
      input  frame_err
   );
endinterface

// File: rtl/master_in_port.sv
// Master-side serial receiver: handshake on data_ready & master_ready, shift in an
// LSB-first word, check framing against slave_tx_done, hold the result for the core.
module master_in_port #(
   parameter int DATA_WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   master_in_port_if.master bus
);
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      RECEIVE = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  valid_q, valid_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  ferr_q, ferr_d;

   // NOTE: every register is cleared by the asynchronous reset, including the
   // shift register, so an aborted reception leaves no stale partial word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from the same
         // pre-edge values computed by the combinational block.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         ferr_q  <= ferr_d;
      end
   end

   // NOTE: defaults first, so no path through this block can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      ferr_d  = 1'b0;

      if (valid_q && bus.dout_ack) begin
         valid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (ready_q && bus.data_ready) begin
               state_d = RECEIVE;
               busy_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         RECEIVE: begin
            shift_d[cnt_q[IDX_W-1:0]] = bus.rx_data;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               // A word is only accepted when the slave marks this exact bit as last.
               if (bus.slave_tx_done) begin
                  dout_d  = shift_d;
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (bus.slave_tx_done) begin
               ferr_d  = 1'b1;
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Ready looks ahead at next-state values so it never offers a handshake
   // that the holding register could not absorb.
   assign ready_d = (state_d == IDLE) && bus.rx_en && !valid_d;

   assign bus.master_ready = ready_q;
   assign bus.dout         = dout_q;
   assign bus.dout_valid   = valid_q;
   assign bus.busy         = busy_q;
   assign bus.frame_err    = ferr_q;

   a_ferr_one_cycle : assert property (
      @(posedge clk) disable iff (reset) ferr_q |=> !ferr_q);

   a_ready_excludes_valid : assert property (
      @(posedge clk) disable iff (reset) ready_q |-> !valid_q);

   a_busy_matches_state : assert property (
      @(posedge clk) disable iff (reset) busy_q == (state_q == RECEIVE));

   a_hold_unacked_word : assert property (
      @(posedge clk) disable iff (reset)
      (valid_q && !bus.dout_ack) |=> (valid_q && $stable(dout_q)));
endmodule

// File: tb/tb_master_in_port.sv
// Directed-vector bench for master_in_port: reset state, framed words, framing
// errors, back-to-back delivery with ack, and abort by reset.
module tb_master_in_port;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   master_in_port_if #(.DATA_WIDTH(8)) bus ();

   master_in_port #(.DATA_WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Handshake edge (E0) followed by bit edges; stops after the edge where
   // slave_tx_done was presented, or after the last bit.
   task automatic rx_word(input logic [7:0] w, input int done_bit);
      bus.data_ready = 1'b1;
      step();
      bus.data_ready = 1'b0;
      check("hs_busy", bus.busy, 1);
      check("hs_ready", bus.master_ready, 0);
      for (int i = 0; i < 8; i++) begin
         bus.rx_data       = w[i];
         bus.slave_tx_done = (i == done_bit);
         step();
         if (i == done_bit) break;
         if (i < 7) check("bit_busy", bus.busy, 1);
      end
      bus.rx_data       = 1'b0;
      bus.slave_tx_done = 1'b0;
   endtask

   task automatic ack_word();
      bus.dout_ack = 1'b1;
      step();
      bus.dout_ack = 1'b0;
      check("ack_valid", bus.dout_valid, 0);
   endtask

   initial begin
      checks            = 0;
      failures          = 0;
      reset             = 1'b1;
      bus.rx_en         = 1'b0;
      bus.data_ready    = 1'b0;
      bus.rx_data       = 1'b0;
      bus.slave_tx_done = 1'b0;
      bus.dout_ack      = 1'b0;

      // Reset state
      step();
      step();
      check("rst_ready", bus.master_ready, 0);
      check("rst_dout", bus.dout, 8'h00);
      check("rst_valid", bus.dout_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ferr", bus.frame_err, 0);
      reset     = 1'b0;
      bus.rx_en = 1'b1;
      step();
      check("idle_ready", bus.master_ready, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle_ready_hold", bus.master_ready, 1);
         check("idle_valid", bus.dout_valid, 0);
         check("idle_dout", bus.dout, 8'h00);
      end

      // Good word 0xA5
      rx_word(8'hA5, 7);
      check("a5_dout", bus.dout, 8'hA5);
      check("a5_valid", bus.dout_valid, 1);
      check("a5_busy", bus.busy, 0);
      check("a5_ready", bus.master_ready, 0);
      check("a5_ferr", bus.frame_err, 0);
      bus.data_ready = 1'b1;
      step();
      step();
      bus.data_ready = 1'b0;
      check("a5_no_hs_busy", bus.busy, 0);
      check("a5_hold_valid", bus.dout_valid, 1);
      check("a5_hold_ready", bus.master_ready, 0);
      ack_word();
      check("a5_ack_ready", bus.master_ready, 1);
      check("a5_ack_dout", bus.dout, 8'hA5);

      // Missing done on last bit
      rx_word(8'hA5, 8);
      check("late_ferr", bus.frame_err, 1);
      check("late_valid", bus.dout_valid, 0);
      check("late_ready", bus.master_ready, 1);
      check("late_busy", bus.busy, 0);
      step();
      check("late_ferr_pulse", bus.frame_err, 0);

      // Early done at E4
      rx_word(8'h5A, 3);
      check("early_ferr", bus.frame_err, 1);
      check("early_busy", bus.busy, 0);
      check("early_ready", bus.master_ready, 1);
      check("early_dout", bus.dout, 8'hA5);
      check("early_valid", bus.dout_valid, 0);
      step();
      check("early_ferr_pulse", bus.frame_err, 0);

      // Back-to-back 0x3C then 0xFF, second handshake at E10
      rx_word(8'h3C, 7);
      check("b2b_dout0", bus.dout, 8'h3C);
      check("b2b_valid0", bus.dout_valid, 1);
      bus.dout_ack   = 1'b1;
      bus.data_ready = 1'b1;
      step();
      bus.dout_ack = 1'b0;
      check("b2b_e9_valid", bus.dout_valid, 0);
      check("b2b_e9_ready", bus.master_ready, 1);
      check("b2b_e9_busy", bus.busy, 0);
      check("b2b_e9_dout", bus.dout, 8'h3C);
      rx_word(8'hFF, 7);
      check("b2b_dout1", bus.dout, 8'hFF);
      check("b2b_valid1", bus.dout_valid, 1);
      ack_word();

      // rx_en low drops master_ready at the next edge
      bus.rx_en = 1'b0;
      step();
      check("rxen_ready", bus.master_ready, 0);
      bus.rx_en = 1'b1;
      step();
      check("rxen_ready_back", bus.master_ready, 1);

      // Reset during reception
      bus.data_ready = 1'b1;
      step();
      bus.data_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.rx_data = 1'b1;
         step();
      end
      check("abort_busy_pre", bus.busy, 1);
      reset = 1'b1;
      #1;
      check("abort_busy", bus.busy, 0);
      check("abort_dout", bus.dout, 8'h00);
      check("abort_ready", bus.master_ready, 0);
      step();
      reset       = 1'b0;
      bus.rx_data = 1'b0;
      step();
      check("abort_valid", bus.dout_valid, 0);
      check("abort_ferr", bus.frame_err, 0);
      check("abort_ready_back", bus.master_ready, 1);
      rx_word(8'h81, 7);
      check("r81_dout", bus.dout, 8'h81);
      check("r81_valid", bus.dout_valid, 1);
      check("r81_ferr", bus.frame_err, 0);
      ack_word();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
